// File: rtl/arb_mux_reg_if.sv
// -----------------------------------------------------------------------------
// arb_mux_reg_if
//   Handshake bundle between N producers, the arbitrating selector and one
//   consumer.
//
//   Parameters
//     WIDTH      data width per channel
//     N          number of input channels
//   Signals
//     in_valid   [N]          per-channel valid from the producers
//     in_data    [N*WIDTH]    channel i occupies bits [i*WIDTH +: WIDTH]
//     in_ready   [N]          per-channel ready back to the producers
//     out_valid  [1]          registered output valid
//     out_data   [WIDTH]      registered selected data
//     out_sel    [SW]         registered index of the supplying channel
//     out_ready  [1]          consumer ready
//   Modports
//     slave      the selector's view
//     master     the producers'/consumer's (environment) view
// -----------------------------------------------------------------------------
interface arb_mux_reg_if #(
   parameter int WIDTH = 32,
   parameter int N     = 8
);
   localparam int SW = $clog2(N);

   logic [N-1:0]       in_valid;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   out_data;
   logic [SW-1:0]      out_sel;
   logic               out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/arb_mux_reg.sv
// -----------------------------------------------------------------------------
// arb_mux_reg
//   N-channel, WIDTH-bit arbitrating selector with a registered output stage.
//   Every cycle one valid channel is chosen (fixed priority or round-robin);
//   when the output register can load, the chosen channel is handshaked and
//   its word is registered together with its channel index.
//
//   Parameters
//     WIDTH   data width per channel (>= 1)
//     N       number of input channels (>= 2, any value)
//     MODE    0 = fixed priority (lowest index wins), 1 = round-robin
//   Ports
//     clk     clock, all state updates on the rising edge
//     reset   synchronous, active-high reset
//     bus     arb_mux_reg_if.slave: in_valid/in_data/in_ready per channel,
//             out_valid/out_data/out_sel/out_ready towards the consumer
// -----------------------------------------------------------------------------
module arb_mux_reg #(
   parameter  int WIDTH = 32,
   parameter  int N     = 8,
   parameter  int MODE  = 1,
   localparam int SW    = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset,
   arb_mux_reg_if.slave bus
);

   logic          load;        // output register may take a new word
   logic          any_valid;
   logic          accept;
   logic [SW-1:0] grant;
   logic [SW-1:0] ptr;         // round-robin search start

   assign load      = ~bus.out_valid | bus.out_ready;
   assign any_valid = |bus.in_valid;
   assign accept    = |(bus.in_valid & bus.in_ready);

   always_comb begin : arbitrate
      int  idx;
      logic found;
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      grant = '0;
      idx   = 0;
      found = 1'b0;
      if (MODE == 0) begin
         // Scan downwards so the lowest valid index is the last to win.
         for (int i = N - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) grant = SW'(i);
         end
      end else begin
         // Search ptr, ptr+1, ... wrapping at N (N need not be a power of 2).
         for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && bus.in_valid[idx]) begin
               grant = SW'(idx);
               found = 1'b1;
            end
         end
      end
   end

   // Ready goes only to the granted channel; it depends on valid and
   // out_ready but never on any ready bit.
   always_comb begin : ready_gen
      bus.in_ready = '0;
      if (!reset && load && any_valid) bus.in_ready[grant] = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sel   <= '0;
         ptr           <= '0;
      end else if (load) begin
         if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data[int'(grant)*WIDTH +: WIDTH];
            bus.out_sel   <= grant;
            if (MODE == 1) ptr <= (grant == SW'(N - 1)) ? '0 : grant + SW'(1);
         end else begin
            // Drained with nothing to replace it: bubble, data/sel hold.
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_reg.sv
// -----------------------------------------------------------------------------
// tb_arb_mux_reg
//   Three instances: 8-channel round-robin, 8-channel fixed priority and
//   5-channel round-robin. Stimulus pushes the expected {sel, data} of every
//   accepted word into a per-instance queue; monitors pop and compare each
//   time an instance hands a word to its consumer.
// -----------------------------------------------------------------------------
module tb_arb_mux_reg;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   arb_mux_reg_if #(.WIDTH(32), .N(8)) rr_if ();
   arb_mux_reg_if #(.WIDTH(32), .N(8)) fp_if ();
   arb_mux_reg_if #(.WIDTH(32), .N(5)) n5_if ();

   arb_mux_reg #(.WIDTH(32), .N(8), .MODE(1)) u_rr (.clk(clk), .reset(reset), .bus(rr_if.slave));
   arb_mux_reg #(.WIDTH(32), .N(8), .MODE(0)) u_fp (.clk(clk), .reset(reset), .bus(fp_if.slave));
   arb_mux_reg #(.WIDTH(32), .N(5), .MODE(1)) u_n5 (.clk(clk), .reset(reset), .bus(n5_if.slave));

   typedef struct {
      int          sel;
      logic [31:0] data;
   } exp_t;

   exp_t q_rr[$];
   exp_t q_fp[$];
   exp_t q_n5[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic extra_word(input string name, input logic [31:0] sel, input logic [31:0] data);
      checks++;
      errors++;
      $display("FAIL %s: unexpected word sel=%0d data=%0h, expected none (t=%0t)", name, sel, data, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- monitors
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && rr_if.out_valid === 1'b1 && rr_if.out_ready === 1'b1) begin
         if (q_rr.size() == 0) extra_word("rr_out", 32'(rr_if.out_sel), rr_if.out_data);
         else begin
            e = q_rr.pop_front();
            check("rr_out_sel", 64'(rr_if.out_sel), 64'(e.sel));
            check("rr_out_data", 64'(rr_if.out_data), 64'(e.data));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && fp_if.out_valid === 1'b1 && fp_if.out_ready === 1'b1) begin
         if (q_fp.size() == 0) extra_word("fp_out", 32'(fp_if.out_sel), fp_if.out_data);
         else begin
            e = q_fp.pop_front();
            check("fp_out_sel", 64'(fp_if.out_sel), 64'(e.sel));
            check("fp_out_data", 64'(fp_if.out_data), 64'(e.data));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b0 && n5_if.out_valid === 1'b1 && n5_if.out_ready === 1'b1) begin
         if (q_n5.size() == 0) extra_word("n5_out", 32'(n5_if.out_sel), n5_if.out_data);
         else begin
            e = q_n5.pop_front();
            check("n5_out_sel", 64'(n5_if.out_sel), 64'(e.sel));
            check("n5_out_data", 64'(n5_if.out_data), 64'(e.data));
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   int rr_seq[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 7, 2, 7};
   int n5_seq[10] = '{0, 1, 2, 3, 4, 0, 1, 4, 0, 4};

   initial begin
      logic [7:0] pend;
      logic       m_ov;
      int         m_ptr;
      int         seqn;
      int         g;
      logic       load;

      reset           = 1'b1;
      rr_if.in_valid  = '1;
      fp_if.in_valid  = '1;
      n5_if.in_valid  = '1;
      rr_if.out_ready = 1'b1;
      fp_if.out_ready = 1'b1;
      n5_if.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rr_if.in_data[i*32 +: 32] = 32'h100 + i;
         fp_if.in_data[i*32 +: 32] = 32'h200 + i;
      end
      for (int i = 0; i < 5; i++) n5_if.in_data[i*32 +: 32] = 32'h300 + i;

      // ---- reset with every channel valid
      repeat (2) begin
         step();
         check("rst_rr_ready", 64'(rr_if.in_ready), 64'h0);
         check("rst_fp_ready", 64'(fp_if.in_ready), 64'h0);
         check("rst_n5_ready", 64'(n5_if.in_ready), 64'h0);
         check("rst_out_valid", 64'(rr_if.out_valid), 64'h0);
         check("rst_out_data", 64'(rr_if.out_data), 64'h0);
         check("rst_out_sel", 64'(rr_if.out_sel), 64'h0);
      end
      fp_if.in_valid = '0;
      n5_if.in_valid = '0;
      reset          = 1'b0;

      // ---- round-robin over all eight, then 8'b1000_0100 from ptr=3
      for (int k = 0; k < 14; k++) begin
         if (k == 11) rr_if.in_valid = 8'h84;
         #1;
         check("rr_ready", 64'(rr_if.in_ready), 64'h1 << rr_seq[k]);
         q_rr.push_back('{rr_seq[k], 32'h100 + rr_seq[k]});
         step();
      end

      // ---- idle bubble: last word drains, data and sel hold
      rr_if.in_valid = '0;
      step();
      check("idle_out_valid", 64'(rr_if.out_valid), 64'h0);
      check("idle_out_data", 64'(rr_if.out_data), 64'h107);
      check("idle_out_sel", 64'(rr_if.out_sel), 64'h7);

      // ---- back-pressure on word A from channel 2 (ptr is 0 here)
      rr_if.in_data[2*32 +: 32] = 32'hAAAA_0002;
      rr_if.in_valid = 8'h04;
      #1;
      check("bp_load_ready", 64'(rr_if.in_ready), 64'h04);
      q_rr.push_back('{2, 32'hAAAA_0002});
      step();
      rr_if.out_ready = 1'b0;
      rr_if.in_valid  = 8'hFF;
      repeat (3) begin
         #1;
         check("bp_ready", 64'(rr_if.in_ready), 64'h0);
         check("bp_out_valid", 64'(rr_if.out_valid), 64'h1);
         check("bp_out_data", 64'(rr_if.out_data), 64'hAAAA_0002);
         check("bp_out_sel", 64'(rr_if.out_sel), 64'h2);
         step();
      end
      rr_if.out_ready = 1'b1;
      #1;
      check("bp_release_ready", 64'(rr_if.in_ready), 64'h08);
      q_rr.push_back('{3, 32'h103});
      step();
      rr_if.in_valid = '0;
      rr_if.in_data[2*32 +: 32] = 32'h102;
      step();

      // ---- reset mid-stream discards the held word and clears ptr (ptr is 4)
      rr_if.out_ready = 1'b0;
      rr_if.in_valid  = 8'h02;
      #1;
      check("mid_load_ready", 64'(rr_if.in_ready), 64'h02);
      step();
      check("mid_held_valid", 64'(rr_if.out_valid), 64'h1);
      check("mid_held_data", 64'(rr_if.out_data), 64'h101);
      reset           = 1'b1;
      rr_if.out_ready = 1'b1;
      #1;
      check("mid_rst_ready", 64'(rr_if.in_ready), 64'h0);
      step();
      check("mid_rst_valid", 64'(rr_if.out_valid), 64'h0);
      check("mid_rst_data", 64'(rr_if.out_data), 64'h0);
      check("mid_rst_sel", 64'(rr_if.out_sel), 64'h0);
      reset          = 1'b0;
      rr_if.in_valid = 8'h81;
      #1;
      check("post_rst_ptr_ready", 64'(rr_if.in_ready), 64'h01);
      q_rr.push_back('{0, 32'h100});
      step();
      rr_if.in_valid = '0;
      step();

      // ---- fixed priority: 5 starves 6 until 5 drops
      fp_if.in_valid = 8'h60;
      repeat (4) begin
         #1;
         check("fp_ready_5", 64'(fp_if.in_ready), 64'h20);
         q_fp.push_back('{5, 32'h205});
         step();
      end
      fp_if.in_valid = 8'h40;
      #1;
      check("fp_ready_6", 64'(fp_if.in_ready), 64'h40);
      q_fp.push_back('{6, 32'h206});
      step();
      fp_if.in_valid = '0;
      repeat (2) step();

      // ---- N=5 round-robin: wrap 4 -> 0
      n5_if.in_valid = 5'h1F;
      for (int k = 0; k < 10; k++) begin
         if (k == 7) n5_if.in_valid = 5'h11;
         #1;
         check("n5_ready", 64'(n5_if.in_ready), 64'h1 << n5_seq[k]);
         q_n5.push_back('{n5_seq[k], 32'h300 + n5_seq[k]});
         step();
      end
      n5_if.in_valid = '0;
      repeat (2) step();

      // ---- random traffic on the 8-channel round-robin instance
      reset = 1'b1;
      step();
      reset = 1'b0;
      pend  = '0;
      m_ov  = 1'b0;
      m_ptr = 0;
      seqn  = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int ch = 0; ch < 8; ch++) begin
            if (!pend[ch] && $urandom_range(0, 2) == 0) begin
               pend[ch] = 1'b1;
               rr_if.in_data[ch*32 +: 32] = {8'(ch), 24'(seqn)};
               seqn++;
            end
         end
         rr_if.in_valid  = pend;
         rr_if.out_ready = ($urandom_range(0, 3) != 0);
         load = !m_ov || rr_if.out_ready;
         #1;
         if (load && pend != '0) begin
            g = -1;
            for (int k = 0; k < 8; k++) begin
               if (g < 0 && pend[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
            end
            check("rnd_ready", 64'(rr_if.in_ready), 64'h1 << g);
            q_rr.push_back('{g, rr_if.in_data[g*32 +: 32]});
            pend[g] = 1'b0;
            m_ptr   = (g == 7) ? 0 : g + 1;
            m_ov    = 1'b1;
         end else begin
            check("rnd_ready_idle", 64'(rr_if.in_ready), 64'h0);
            if (load) m_ov = 1'b0;
         end
         step();
      end
      rr_if.in_valid  = '0;
      rr_if.out_ready = 1'b1;
      repeat (3) step();

      check("rr_all_drained", 64'(q_rr.size()), 64'h0);
      check("fp_all_drained", 64'(q_fp.size()), 64'h0);
      check("n5_all_drained", 64'(q_n5.size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
